// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for the EX stage.
// Handles signed and unsigned 32-bit divide/modulo. One quotient bit is
// produced per cycle. ready_o is a pure state decode, so there is no
// combinational path from any input to ready_o.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; results held from the last operation
// CALC  | 32 restoring iterations, one quotient bit per cycle
// DONE  | result valid (ready_o = 1) until start_i drops
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [32:0] rem;
    logic [31:0] dq;
    logic [31:0] dvs;
    logic [4:0]  count;
    logic        neg_q;
    logic        neg_r;

    logic        go;
    logic        div_zero;
    logic        last;
    logic        dend_neg;
    logic        dvs_neg;
    logic [33:0] trial;
    logic        qbit;
    logic [32:0] rem_next;
    logic [31:0] dq_next;

    assign go       = start_i & ~cancel_i;
    assign div_zero = (divisor_i == 32'd0);
    assign last     = (count == 5'd31);
    assign dend_neg = signed_i & dividend_i[31];
    assign dvs_neg  = signed_i & divisor_i[31];

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The partial remainder stays below the divisor, so a borrow out of the
    // 34-bit subtraction means the trial failed and the shifted value is kept.
    always_comb begin
        trial    = {rem, dq[31]} - {2'b00, dvs};
        qbit     = ~trial[33];
        rem_next = qbit ? trial[32:0] : {rem[31:0], dq[31]};
        dq_next  = {dq[30:0], qbit};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; cancel wins over everything, including a held start.
    always_comb begin
        state_next = state;
        if (cancel_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_next = div_zero ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (last) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, iteration, and result write with sign fix-up.
    // quotient_o/remainder_o are written only on the transition into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem         <= '0;
            dq          <= '0;
            dvs         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else if (state == IDLE && go) begin
            // Negating 0x80000000 wraps to itself, which is its correct
            // unsigned magnitude.
            dq    <= dend_neg ? (-dividend_i) : dividend_i;
            dvs   <= dvs_neg ? (-divisor_i) : divisor_i;
            neg_q <= dend_neg ^ dvs_neg;
            neg_r <= dend_neg;
            rem   <= '0;
            count <= '0;
            if (div_zero) begin
                quotient_o  <= 32'hFFFF_FFFF;
                remainder_o <= dividend_i;
            end
        end else if (state == CALC && !cancel_i) begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + 5'd1;
            if (last) begin
                quotient_o  <= neg_q ? (-dq_next) : dq_next;
                remainder_o <= neg_r ? (-rem_next[31:0]) : rem_next[31:0];
            end
        end
    end

    assign ready_o = (state == DONE);
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a table of divisions with hand-computed
// results and latencies, followed by cancel, reset and hold sequences.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic        ready_o;
    logic        busy_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start a division, scramble operands after the sampling edge, count edges
    // to ready_o, compare results, optionally hold start through DONE, then
    // drop start and confirm the return to IDLE.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int lat, input int hold);
        int cyc;
        @(negedge clk);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                signed_i   = ~sgn;
                dividend_i = $urandom;
                divisor_i  = $urandom;
            end
        end while (!ready_o && cyc < 45);
        chk({name, " latency"}, cyc, lat);
        chk({name, " quotient"}, quotient_o, eq);
        chk({name, " remainder"}, remainder_o, er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, " hold ready"}, {31'd0, ready_o}, 32'd1);
            chk({name, " hold quotient"}, quotient_o, eq);
            chk({name, " hold remainder"}, remainder_o, er);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " idle busy"}, {31'd0, busy_o}, 32'd0);
        chk({name, " idle ready"}, {31'd0, ready_o}, 32'd0);
        chk({name, " idle quotient"}, quotient_o, eq);
    endtask

    initial begin
        vecs[0] = '{"u 100/7",        1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[1] = '{"s -7/2",         1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2] = '{"s 7/-2",         1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
        vecs[3] = '{"u fff9/2",       1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 32'h00000001, 33};
        vecs[4] = '{"div0",           1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF, 32'h12345678, 1};
        vecs[5] = '{"s min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
        vecs[6] = '{"s -100/-7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 33};
        vecs[7] = '{"u 8000/ffff",    1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
        vecs[8] = '{"s div0 neg",     1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9, 1};
        vecs[9] = '{"u ffff/1",       1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 33};

        rst        = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        cancel_i   = 1'b0;
        #23;
        chk("reset ready", {31'd0, ready_o}, 32'd0);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset quotient", quotient_o, 32'd0);
        chk("reset remainder", remainder_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].lat, 0);
        end

        // Start and cancel together in IDLE: nothing starts.
        @(negedge clk);
        signed_i   = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        cancel_i   = 1'b1;
        @(posedge clk);
        #1;
        chk("start+cancel busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;

        // Cancel during CALC cycle 10; last results (u ffff/1) stay put.
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        cancel_i = 1'b1;
        start_i  = 1'b0;
        @(posedge clk);
        #1;
        chk("cancel busy", {31'd0, busy_o}, 32'd0);
        chk("cancel ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        begin
            int seen = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (ready_o) seen = 1;
            end
            chk("cancel no ready", seen, 0);
        end
        chk("cancel quotient held", quotient_o, 32'hFFFFFFFF);
        chk("cancel remainder held", remainder_o, 32'h00000000);
        run_div("u 9/3 after cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

        // Reset in CALC cycle 20 clears outputs without waiting for an edge.
        @(negedge clk);
        dividend_i = 32'd77;
        divisor_i  = 32'd5;
        start_i    = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy_o}, 32'd0);
        chk("async reset quotient", quotient_o, 32'd0);
        chk("async reset remainder", remainder_o, 32'd0);
        start_i = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset idle", {31'd0, busy_o}, 32'd0);

        // Start held through DONE for 5 extra cycles: no restart, stable result.
        run_div("u 77/5 hold", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 33, 5);

        // Cancel in DONE with start still high, then a held start restarts.
        @(negedge clk);
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        chk("div0 ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        cancel_i   = 1'b1;
        dividend_i = 32'd20;
        divisor_i  = 32'd4;
        @(posedge clk);
        #1;
        chk("done cancel busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        @(posedge clk);
        #1;
        chk("restart busy", {31'd0, busy_o}, 32'd1);
        chk("restart not ready", {31'd0, ready_o}, 32'd0);
        begin
            int cyc = 1;
            while (!ready_o && cyc < 45) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("restart latency", cyc, 33);
        end
        chk("restart quotient", quotient_o, 32'd5);
        chk("restart remainder", remainder_o, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller and datapath for the EX stage. It executes LoongArch DIV.W/MOD.W/DIV.WU/MOD.WU as a 32-iteration radix-2 restoring division, one quotient bit per cycle. It produces a ready handshake that EX uses to stall the pipeline while a division is in flight. EX selects quotient or remainder for the register write; this block only sequences and computes.

## Interface
Parameters:
- none (widths fixed at 32 bits, `RegWidth`)

Ports:
- `clk` input 1: system clock, all state on rising edge
- `rst` input 1: asynchronous, active-low reset
- `start_i` input 1: EX requests a division; held high until `ready_o` seen, then dropped
- `signed_i` input 1: 1 = signed (DIV.W/MOD.W), 0 = unsigned; sampled with `start_i` in IDLE
- `dividend_i` input 32: reg1 operand; sampled in IDLE
- `divisor_i` input 32: reg2 operand; sampled in IDLE
- `cancel_i` input 1: pipeline flush; aborts any operation
- `ready_o` output 1: result valid, high only in DONE
- `busy_o` output 1: state ≠ IDLE
- `quotient_o` output 32: registered quotient
- `remainder_o` output 32: registered remainder

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE with `start_i` = 1 and `cancel_i` = 0:
  - Latch sign flags of the dividend and divisor (when `signed_i`).
  - Latch absolute values; |−2^31| = 0x80000000 as unsigned.
  - If divisor = 0 → DONE with quotient 0xFFFFFFFF, remainder = raw `dividend_i`.
  - Otherwise clear the 33-bit partial remainder and the iteration counter (5-bit), then → CALC.
- CALC, each cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor (33-bit).
  - If the result is non-negative, keep the difference and the quotient bit = 1; else restore and the quotient bit = 0.
  - Shift the dividend/quotient register.
  - The counter increments; at count 31 → DONE.
- Entering DONE from CALC, sign fix-up:
  - Quotient negated (two's complement) if signed and the operand signs differ.
  - Remainder negated if signed and the dividend is negative.
  - Result written into `quotient_o`/`remainder_o`.
- −2^31 / −1 signed gives quotient 0x80000000, remainder 0 (natural wrap, no exception).
- DONE: `ready_o` = 1. Stay while `start_i` = 1; → IDLE when `start_i` = 0. No new division starts until IDLE is re-entered.
- `cancel_i` = 1 in any state → IDLE next edge. It has priority over `start_i`. Outputs keep their previous values. `ready_o` drops next cycle.
- `quotient_o`/`remainder_o` change only on DONE entry; they are held otherwise, including through IDLE.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state = IDLE, counter = 0, internal registers = 0.
  - `ready_o` = 0, `busy_o` = 0, `quotient_o` = 0, `remainder_o` = 0.
- Start sampled at edge 0 (cycle 0 in IDLE). CALC occupies cycles 1–32. DONE from cycle 33.
  - `ready_o` high in cycle 33: 33-cycle latency.
- Divide-by-zero: `ready_o` high in cycle 1.
- EX stall request is `start_i & ~ready_o`, computed in EX. This block provides no combinational path from inputs to `ready_o`.
- Operands may change after edge 0 without effect.
- Reset asserted mid-CALC clears immediately. After release, the block is in IDLE and needs a fresh `start_i`.
- Simultaneous `start_i` and `cancel_i` in IDLE: no start.
- `cancel_i` in DONE: IDLE next edge, even if `start_i` is still high. A start still high in IDLE one cycle later is treated as a new request.

## Test plan
- Unsigned 100 / 7, start held → `ready_o` rises in cycle 33; quotient 14 (0x0000000E), remainder 2; drop start → IDLE next edge, `busy_o` = 0.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1. Unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Divisor 0, dividend 0x12345678 → `ready_o` in cycle 1; quotient 0xFFFFFFFF, remainder 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 at cycle 33.
- `cancel_i` pulse in cycle 10 of CALC → IDLE at cycle 11, `ready_o` never rises, outputs unchanged. A new start of 9 / 3 then completes 33 cycles later with quotient 3, remainder 0.
- Reset asserted in cycle 20 of CALC → all outputs 0 immediately. Start held through DONE for 5 extra cycles → outputs stable, no restart.
